hazard_sched_ctrl: RTL and testbench

Pipeline hazard scheduler for the five-stage core. It drives the 2-bit select of the two execute-stage 3:1 operand muxes (SrcA/SrcB forwarding) and sequences stalls, flushes and data-memory wait states. It tracks destination registers of in-flight instructions in an internal shadow pipeline (E, M, W), so decode is its only instruction input.

---
 rtl/hazard_sched_ctrl_pkg.sv | 29 ++
 rtl/hazard_sched_ctrl_if.sv | 40 ++++
 rtl/hazard_sched_ctrl_fwd_sel.sv | 30 +++
 rtl/hazard_sched_ctrl.sv | 152 +++++++++++++++
 tb/tb_hazard_sched_ctrl.sv | 208 ++++++++++++++++++++
 5 files changed

// File: rtl/hazard_sched_ctrl_pkg.sv
// Shared types for the pipeline hazard scheduler: forwarding selects, FSM
// state encoding and the shadow-pipeline entry tracked per in-flight stage.
package hazard_pkg;

    localparam int REG_AW_MAX = 8;

    typedef enum logic [1:0] {
        FWD_RF  = 2'b00,
        FWD_WB  = 2'b01,
        FWD_MEM = 2'b10
    } fwd_sel_t;

    typedef logic [0:0] state_t;
    localparam state_t RUN      = 1'b0;
    localparam state_t MEM_WAIT = 1'b1;

    // Register fields are widened to REG_AW_MAX so one struct serves any REG_AW
    typedef struct packed {
        logic [REG_AW_MAX-1:0] rs1;
        logic [REG_AW_MAX-1:0] rs2;
        logic [REG_AW_MAX-1:0] rd;
        logic                  reg_write;
        logic                  is_load;
        logic                  mem_op;
    } shadow_t;

    localparam shadow_t BUBBLE = '0;

endpackage

// File: rtl/hazard_sched_ctrl_if.sv
// Decode/control bundle between the core pipeline (master) and the hazard
// scheduler (slave).
interface hazard_sched_ctrl_if #(
    parameter int REG_AW = 5
);
    logic              id_valid;
    logic [REG_AW-1:0] id_rs1;
    logic [REG_AW-1:0] id_rs2;
    logic [REG_AW-1:0] id_rd;
    logic              id_reg_write;
    logic              id_is_load;
    logic              id_mem_op;
    logic              ex_pc_src;
    logic              dmem_ready;
    logic [1:0]        fwd_a_e;
    logic [1:0]        fwd_b_e;
    logic              stall_f;
    logic              stall_d;
    logic              stall_e;
    logic              stall_m;
    logic              flush_d;
    logic              flush_e;
    logic              flush_w;
    logic              mem_timeout;

    modport master (
        output id_valid, id_rs1, id_rs2, id_rd, id_reg_write, id_is_load,
               id_mem_op, ex_pc_src, dmem_ready,
        input  fwd_a_e, fwd_b_e, stall_f, stall_d, stall_e, stall_m,
               flush_d, flush_e, flush_w, mem_timeout
    );

    modport slave (
        input  id_valid, id_rs1, id_rs2, id_rd, id_reg_write, id_is_load,
               id_mem_op, ex_pc_src, dmem_ready,
        output fwd_a_e, fwd_b_e, stall_f, stall_d, stall_e, stall_m,
               flush_d, flush_e, flush_w, mem_timeout
    );

endinterface

// File: rtl/hazard_sched_ctrl_fwd_sel.sv
// One execute-stage operand's forwarding select: compares the E source
// register against the M and W destinations.
module hazard_fwd_sel
    import hazard_pkg::*;
(
    input  logic [REG_AW_MAX-1:0] rs_i,
    input  logic [REG_AW_MAX-1:0] m_rd_i,
    input  logic                  m_reg_write_i,
    input  logic [REG_AW_MAX-1:0] w_rd_i,
    input  logic                  w_reg_write_i,
    output fwd_sel_t              sel_o
);

    logic rs_nz_s;

    assign rs_nz_s = (rs_i != '0);

    // M holds the younger result, so it takes priority over W
    always_comb begin
        sel_o = FWD_RF;
        if (rs_nz_s && m_reg_write_i && (m_rd_i == rs_i)) begin
            sel_o = FWD_MEM;
        end else if (rs_nz_s && w_reg_write_i && (w_rd_i == rs_i)) begin
            sel_o = FWD_WB;
        end else begin
            sel_o = FWD_RF;
        end
    end

endmodule

// File: rtl/hazard_sched_ctrl.sv
// Pipeline hazard scheduler: forwarding selects plus stall/flush sequencing
// for branches, load-use hazards and data-memory wait states.
module hazard_sched_ctrl
    import hazard_pkg::*;
#(
    parameter int REG_AW   = 5,
    parameter int MAX_WAIT = 15
) (
    input logic                clk,
    input logic                reset_n,
    hazard_sched_ctrl_if.slave hz
);

    localparam logic [7:0] WAIT_LIMIT = 8'(MAX_WAIT);

    logic [REG_AW-1:0] id_rs1_s;
    logic [REG_AW-1:0] id_rs2_s;
    logic [REG_AW-1:0] id_rd_s;
    shadow_t           id_entry_s;
    shadow_t           e_q, m_q, w_q;
    shadow_t           e_d, m_d, w_d;
    state_t            state_q, state_d;
    logic [7:0]        wait_cnt_q, wait_cnt_d;
    logic              timeout_q, timeout_d;
    logic              wait_s;
    logic              branch_s;
    logic              load_use_s;
    logic              flush_e_s;
    fwd_sel_t          fwd_a_s, fwd_b_s;
    logic              unused_shadow_s;

    assign id_rs1_s = hz.id_rs1;
    assign id_rs2_s = hz.id_rs2;
    assign id_rd_s  = hz.id_rd;

    // Decode instruction widened into shadow format; invalid slots become bubbles
    always_comb begin
        id_entry_s = BUBBLE;
        if (hz.id_valid) begin
            id_entry_s.rs1       = REG_AW_MAX'(id_rs1_s);
            id_entry_s.rs2       = REG_AW_MAX'(id_rs2_s);
            id_entry_s.rd        = REG_AW_MAX'(id_rd_s);
            id_entry_s.reg_write = hz.id_reg_write;
            id_entry_s.is_load   = hz.id_is_load;
            id_entry_s.mem_op    = hz.id_mem_op;
        end else begin
            id_entry_s = BUBBLE;
        end
    end

    // A pending memory access outranks the branch, which outranks load-use
    assign wait_s     = m_q.mem_op & ~hz.dmem_ready;
    assign branch_s   = hz.ex_pc_src & ~wait_s;
    assign load_use_s = ~wait_s & ~hz.ex_pc_src & hz.id_valid & e_q.is_load
                      & (e_q.rd != '0)
                      & ((e_q.rd == id_entry_s.rs1) | (e_q.rd == id_entry_s.rs2));
    assign flush_e_s  = branch_s | load_use_s;

    assign hz.stall_f     = reset_n & (wait_s | load_use_s);
    assign hz.stall_d     = reset_n & (wait_s | load_use_s);
    assign hz.stall_e     = reset_n & wait_s;
    assign hz.stall_m     = reset_n & wait_s;
    assign hz.flush_d     = reset_n & branch_s;
    assign hz.flush_e     = reset_n & flush_e_s;
    assign hz.flush_w     = reset_n & wait_s;
    assign hz.mem_timeout = timeout_q;

    hazard_fwd_sel u_fwd_a (
        .rs_i          (e_q.rs1),
        .m_rd_i        (m_q.rd),
        .m_reg_write_i (m_q.reg_write),
        .w_rd_i        (w_q.rd),
        .w_reg_write_i (w_q.reg_write),
        .sel_o         (fwd_a_s)
    );

    hazard_fwd_sel u_fwd_b (
        .rs_i          (e_q.rs2),
        .m_rd_i        (m_q.rd),
        .m_reg_write_i (m_q.reg_write),
        .w_rd_i        (w_q.rd),
        .w_reg_write_i (w_q.reg_write),
        .sel_o         (fwd_b_s)
    );

    assign hz.fwd_a_e = fwd_a_s;
    assign hz.fwd_b_e = fwd_b_s;

    // Shadow pipeline advance: E/M freeze during a memory wait while W drains
    always_comb begin
        e_d = e_q;
        m_d = m_q;
        w_d = w_q;
        if (wait_s) begin
            e_d = e_q;
            m_d = m_q;
            w_d = BUBBLE;
        end else begin
            e_d = flush_e_s ? BUBBLE : id_entry_s;
            m_d = e_q;
            w_d = m_q;
        end
    end

    // FSM next state
    always_comb begin
        state_d = state_q;
        case (state_q)
            RUN:      state_d = wait_s ? MEM_WAIT : RUN;
            MEM_WAIT: state_d = hz.dmem_ready ? RUN : MEM_WAIT;
            default:  state_d = RUN;
        endcase
    end

    // Saturating wait counter; timeout is sticky once the limit is reached
    always_comb begin
        wait_cnt_d = 8'd0;
        timeout_d  = timeout_q;
        if ((state_q == MEM_WAIT) && !hz.dmem_ready) begin
            wait_cnt_d = (wait_cnt_q == 8'hFF) ? wait_cnt_q : (wait_cnt_q + 8'd1);
            if (wait_cnt_d == WAIT_LIMIT) begin
                timeout_d = 1'b1;
            end else begin
                timeout_d = timeout_q;
            end
        end else begin
            wait_cnt_d = 8'd0;
        end
    end

    // State registers
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            e_q        <= BUBBLE;
            m_q        <= BUBBLE;
            w_q        <= BUBBLE;
            state_q    <= RUN;
            wait_cnt_q <= 8'd0;
            timeout_q  <= 1'b0;
        end else begin
            e_q        <= e_d;
            m_q        <= m_d;
            w_q        <= w_d;
            state_q    <= state_d;
            wait_cnt_q <= wait_cnt_d;
            timeout_q  <= timeout_d;
        end
    end

    assign unused_shadow_s = ^{w_q.rs1, w_q.rs2, w_q.is_load, w_q.mem_op};

endmodule

// File: tb/tb_hazard_sched_ctrl.sv
// Directed bench for hazard_sched_ctrl: stimulus pushes hand-computed
// expectations into a queue; a negedge monitor pops and compares them.
module tb_hazard_sched_ctrl;

    typedef struct packed {
        logic [1:0] fa;
        logic [1:0] fb;
        logic [3:0] st;
        logic [2:0] fl;
        logic       to;
    } obs_t;

    localparam logic [3:0] S0  = 4'b0000;
    localparam logic [3:0] SLU = 4'b1100;
    localparam logic [3:0] SMW = 4'b1111;
    localparam logic [2:0] F0  = 3'b000;
    localparam logic [2:0] FLU = 3'b010;
    localparam logic [2:0] FBR = 3'b110;
    localparam logic [2:0] FMW = 3'b001;

    logic clk;
    logic reset_n;
    obs_t  exp_q[$];
    string name_q[$];
    int    n_checks;
    int    n_fail;

    hazard_sched_ctrl_if #(.REG_AW(5)) hz();

    hazard_sched_ctrl #(.REG_AW(5), .MAX_WAIT(2)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .hz      (hz)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached, want finish before 100000");
        $fatal(1);
    end

    always @(negedge clk) begin
        obs_t  e;
        obs_t  a;
        string nm;
        if (exp_q.size() > 0) begin
            e    = exp_q.pop_front();
            nm   = name_q.pop_front();
            a.fa = hz.fwd_a_e;
            a.fb = hz.fwd_b_e;
            a.st = {hz.stall_f, hz.stall_d, hz.stall_e, hz.stall_m};
            a.fl = {hz.flush_d, hz.flush_e, hz.flush_w};
            a.to = hz.mem_timeout;
            n_checks++;
            if (a !== e) begin
                n_fail++;
                $display("FAIL %s: got fa=%b fb=%b stall=%b flush=%b to=%b, want fa=%b fb=%b stall=%b flush=%b to=%b",
                         nm, a.fa, a.fb, a.st, a.fl, a.to, e.fa, e.fb, e.st, e.fl, e.to);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [4:0] rs1, input logic [4:0] rs2,
                         input logic [4:0] rd, input logic rw, input logic ld,
                         input logic mo, input logic pc, input logic rdy);
        hz.id_valid     = v;
        hz.id_rs1       = rs1;
        hz.id_rs2       = rs2;
        hz.id_rd        = rd;
        hz.id_reg_write = rw;
        hz.id_is_load   = ld;
        hz.id_mem_op    = mo;
        hz.ex_pc_src    = pc;
        hz.dmem_ready   = rdy;
    endtask

    task automatic nop(input logic rdy);
        drive(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, rdy);
    endtask

    task automatic expect_o(input logic [1:0] fa, input logic [1:0] fb, input logic [3:0] st,
                            input logic [2:0] fl, input logic to, input string nm);
        obs_t e;
        e.fa = fa;
        e.fb = fb;
        e.st = st;
        e.fl = fl;
        e.to = to;
        exp_q.push_back(e);
        name_q.push_back(nm);
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        reset_n  = 1'b0;
        drive(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1);

        // reset: branch input must not leak through
        tick(); expect_o(2'b00, 2'b00, S0, F0, 1'b0, "reset_pc_gated");
        tick(); expect_o(2'b00, 2'b00, S0, F0, 1'b0, "reset_hold");
        tick(); reset_n = 1'b1; nop(1'b1);
        expect_o(2'b00, 2'b00, S0, F0, 1'b0, "idle_after_reset");

        // x5 producer followed by consumers
        tick(); drive(1'b1, 5'd1, 5'd2, 5'd5, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
        expect_o(2'b00, 2'b00, S0, F0, 1'b0, "i1_issue");
        tick(); drive(1'b1, 5'd5, 5'd6, 5'd8, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
        expect_o(2'b00, 2'b00, S0, F0, 1'b0, "i2_no_fwd");
        tick(); drive(1'b1, 5'd9, 5'd5, 5'd10, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
        expect_o(2'b10, 2'b00, S0, F0, 1'b0, "fwd_a_mem_x5");
        tick(); nop(1'b1);
        expect_o(2'b00, 2'b01, S0, F0, 1'b0, "fwd_b_wb_x5");

        // M and W both write x7; then x0 never forwards
        tick(); drive(1'b1, 5'd0, 5'd0, 5'd7, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
        expect_o(2'b00, 2'b00, S0, F0, 1'b0, "j1_issue");
        tick(); drive(1'b1, 5'd0, 5'd0, 5'd7, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
        expect_o(2'b00, 2'b00, S0, F0, 1'b0, "j2_issue");
        tick(); drive(1'b1, 5'd7, 5'd0, 5'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
        expect_o(2'b00, 2'b00, S0, F0, 1'b0, "j3_issue");
        tick(); drive(1'b1, 5'd0, 5'd0, 5'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
        expect_o(2'b10, 2'b00, S0, F0, 1'b0, "fwd_m_beats_w_x7");
        tick(); nop(1'b1);
        expect_o(2'b00, 2'b00, S0, F0, 1'b0, "fwd_x0_never");

        // load x3 then consumer of x3 on rs2
        tick(); drive(1'b1, 5'd4, 5'd0, 5'd3, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1);
        expect_o(2'b00, 2'b00, S0, F0, 1'b0, "load_issue");
        tick(); drive(1'b1, 5'd1, 5'd3, 5'd11, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
        expect_o(2'b00, 2'b00, SLU, FLU, 1'b0, "load_use_stall");
        tick(); drive(1'b1, 5'd1, 5'd3, 5'd11, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
        expect_o(2'b00, 2'b00, S0, F0, 1'b0, "load_use_one_cycle");
        tick(); nop(1'b1);
        expect_o(2'b00, 2'b01, S0, F0, 1'b0, "load_use_fwd_wb");

        // branch coincides with load-use
        tick(); drive(1'b1, 5'd0, 5'd0, 5'd12, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1);
        expect_o(2'b00, 2'b00, S0, F0, 1'b0, "load2_issue");
        tick(); drive(1'b1, 5'd12, 5'd0, 5'd13, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1);
        expect_o(2'b00, 2'b00, S0, FBR, 1'b0, "branch_over_load_use");
        tick(); nop(1'b1);
        expect_o(2'b00, 2'b00, S0, F0, 1'b0, "after_branch");

        // store waits 2 cycles: below the timeout limit
        tick(); drive(1'b1, 5'd2, 5'd2, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1);
        expect_o(2'b00, 2'b00, S0, F0, 1'b0, "store_issue");
        tick(); nop(1'b1);
        expect_o(2'b00, 2'b00, S0, F0, 1'b0, "store_in_e");
        tick(); drive(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        expect_o(2'b00, 2'b00, SMW, FMW, 1'b0, "mem_wait_branch_ignored");
        tick(); nop(1'b0);
        expect_o(2'b00, 2'b00, SMW, FMW, 1'b0, "mem_wait_2");
        tick(); nop(1'b1);
        expect_o(2'b00, 2'b00, S0, F0, 1'b0, "mem_release_no_timeout");

        // load x14 waits 3 cycles: exceeds limit of 2
        tick(); drive(1'b1, 5'd0, 5'd0, 5'd14, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1);
        expect_o(2'b00, 2'b00, S0, F0, 1'b0, "load3_issue");
        tick(); nop(1'b1);
        expect_o(2'b00, 2'b00, S0, F0, 1'b0, "load3_in_e");
        for (int i = 0; i < 3; i++) begin
            tick(); drive(1'b1, 5'd14, 5'd0, 5'd15, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
            expect_o(2'b00, 2'b00, SMW, FMW, 1'b0, $sformatf("mem_wait3_%0d", i));
        end
        tick(); drive(1'b1, 5'd14, 5'd0, 5'd15, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
        expect_o(2'b00, 2'b00, S0, F0, 1'b1, "timeout_set");
        tick(); nop(1'b1);
        expect_o(2'b01, 2'b00, S0, F0, 1'b1, "fwd_wb_after_wait");
        tick(); drive(1'b1, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1);
        expect_o(2'b00, 2'b00, S0, F0, 1'b1, "timeout_sticky");
        tick(); nop(1'b1);
        expect_o(2'b00, 2'b00, S0, F0, 1'b1, "timeout_sticky_2");

        // reset asserted in the middle of a wait
        tick(); nop(1'b0);
        expect_o(2'b00, 2'b00, SMW, FMW, 1'b1, "mem_wait4_1");
        tick(); nop(1'b0);
        expect_o(2'b00, 2'b00, SMW, FMW, 1'b1, "mem_wait4_2");
        tick(); reset_n = 1'b0; drive(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        expect_o(2'b00, 2'b00, S0, F0, 1'b0, "reset_mid_wait");
        tick(); reset_n = 1'b1; nop(1'b0);
        expect_o(2'b00, 2'b00, S0, F0, 1'b0, "run_after_reset");
        tick(); nop(1'b1);
        expect_o(2'b00, 2'b00, S0, F0, 1'b0, "fwd_rf_after_reset");

        for (int i = 0; i < 10 && exp_q.size() > 0; i++) begin
            @(negedge clk);
            #1;
        end
        if (exp_q.size() > 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL drain: got %0d pending expectations, want 0", exp_q.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
